ir_tx: RTL and testbench

IR_TX -- requirements
Module: ir_tx

---
 rtl/ir_tx_pkg.sv | 30 +++
 rtl/ir_tx_us_tick.sv | 28 ++
 rtl/nco.sv | 23 ++
 rtl/ir_tx.sv | 141 ++++++++++++++
 tb/tb_ir_tx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ir_tx_pkg.sv
// Shared NEC IR definitions: FSM state encoding, counter widths and the
// protocol phase durations in microseconds (also used by the ir_rx thresholds).
package ir_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LEAD_MARK  = 3'd1,
      ST_LEAD_SPACE = 3'd2,
      ST_BIT_MARK   = 3'd3,
      ST_BIT_SPACE  = 3'd4,
      ST_STOP_MARK  = 3'd5,
      ST_DONE       = 3'd6
   } ir_state_t;

   localparam int US_W     = 14;
   localparam int BIT_W    = 5;
   localparam int NUM_BITS = 32;

   localparam int LEAD_MARK_US  = 9000;
   localparam int LEAD_SPACE_US = 4500;
   localparam int BIT_MARK_US   = 560;
   localparam int ZERO_SPACE_US = 560;
   localparam int ONE_SPACE_US  = 1690;
   localparam int STOP_MARK_US  = 560;

   function automatic logic is_mark(input ir_state_t s);
      return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
   endfunction

endpackage

// File: rtl/ir_tx_us_tick.sv
// 1 us strobe from a CLK_DIV prescaler; clr restarts the period so the first
// strobe lands exactly CLK_DIV cycles after it.
module us_tick #(
   parameter int CLK_DIV = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr || (cnt == '0))
         cnt <= RELOAD;
      else
         cnt <= cnt - CW'(1);
   end

   assign tick = (cnt == '0) && !clr;

endmodule

// File: rtl/nco.sv
// Free-running divide-by-N square wave; high for roughly the first half of
// every i_nco_num clk period.
module nco (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] i_nco_num,
   output logic        o_nco
);

   logic [15:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (cnt == '0)
         cnt <= i_nco_num - 16'd1;
      else
         cnt <= cnt - 16'd1;
   end

   assign o_nco = (cnt >= (i_nco_num >> 1));

endmodule

// File: rtl/ir_tx.sv
// NEC infrared frame transmitter: lead mark/space, 32 bits MSB first, stop mark,
// with optional carrier gating of the marks.
//
//   state      | meaning
//   -----------+------------------------------------------------
//   IDLE       | waiting for i_start, emitter off
//   LEAD_MARK  | 9 ms leader burst
//   LEAD_SPACE | 4.5 ms leader gap
//   BIT_MARK   | 560 us burst opening each bit
//   BIT_SPACE  | 560 us ('0') or 1690 us ('1') gap, shreg MSB selects
//   STOP_MARK  | 560 us trailing burst
//   DONE       | one-cycle o_done pulse
module ir_tx
   import ir_tx_pkg::*;
#(
   parameter int CLK_DIV       = 50,
   parameter int CARRIER_EN    = 0,
   parameter int CARRIER_NUM   = 1316,
   parameter int T_LEAD_MARK   = LEAD_MARK_US,
   parameter int T_LEAD_SPACE  = LEAD_SPACE_US,
   parameter int T_BIT_MARK    = BIT_MARK_US,
   parameter int T_ZERO_SPACE  = ZERO_SPACE_US,
   parameter int T_ONE_SPACE   = ONE_SPACE_US,
   parameter int T_STOP_MARK   = STOP_MARK_US
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_data,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_ir_tx
);

   localparam logic [US_W-1:0] D_LM   = US_W'(T_LEAD_MARK);
   localparam logic [US_W-1:0] D_LS   = US_W'(T_LEAD_SPACE);
   localparam logic [US_W-1:0] D_BM   = US_W'(T_BIT_MARK);
   localparam logic [US_W-1:0] D_ZERO = US_W'(T_ZERO_SPACE);
   localparam logic [US_W-1:0] D_ONE  = US_W'(T_ONE_SPACE);
   localparam logic [US_W-1:0] D_SM   = US_W'(T_STOP_MARK);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);

   ir_state_t        state, state_nx;
   logic [US_W-1:0]  us_cnt;
   logic [US_W-1:0]  dur;
   logic [BIT_W-1:0] bit_cnt;
   logic [31:0]      shreg;
   logic             tick, tick_clr, phase_end, timed, carrier;

   us_tick #(.CLK_DIV(CLK_DIV)) u_us_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tick_clr),
      .tick  (tick)
   );

   always_comb begin
      dur   = '0;
      timed = 1'b1;
      case (state)
         ST_LEAD_MARK:  dur = D_LM;
         ST_LEAD_SPACE: dur = D_LS;
         ST_BIT_MARK:   dur = D_BM;
         ST_BIT_SPACE:  dur = shreg[31] ? D_ONE : D_ZERO;
         ST_STOP_MARK:  dur = D_SM;
         default:       timed = 1'b0;
      endcase
   end

   assign phase_end = timed && tick && (us_cnt == dur - US_W'(1));

   always_comb begin
      state_nx = state;
      tick_clr = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               state_nx = ST_LEAD_MARK;
               tick_clr = 1'b1;
            end
         end
         ST_LEAD_MARK:  if (phase_end) state_nx = ST_LEAD_SPACE;
         ST_LEAD_SPACE: if (phase_end) state_nx = ST_BIT_MARK;
         ST_BIT_MARK:   if (phase_end) state_nx = ST_BIT_SPACE;
         ST_BIT_SPACE: begin
            if (phase_end)
               state_nx = (bit_cnt == LAST_BIT) ? ST_STOP_MARK : ST_BIT_MARK;
         end
         ST_STOP_MARK:  if (phase_end) state_nx = ST_DONE;
         ST_DONE:       state_nx = ST_IDLE;
         default:       state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // us_cnt counts ticks elapsed in the current phase and restarts on every phase change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         us_cnt  <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (tick_clr) begin
         us_cnt  <= '0;
         bit_cnt <= '0;
         shreg   <= i_data;
      end else if (phase_end) begin
         us_cnt <= '0;
         if (state == ST_BIT_SPACE) begin
            shreg <= {shreg[30:0], 1'b0};
            if (bit_cnt != LAST_BIT)
               bit_cnt <= bit_cnt + BIT_W'(1);
         end
      end else if (tick && timed) begin
         us_cnt <= us_cnt + US_W'(1);
      end
   end

   generate
      if (CARRIER_EN != 0) begin : g_carrier
         nco u_nco (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_nco_num (16'(CARRIER_NUM)),
            .o_nco     (carrier)
         );
      end else begin : g_no_carrier
         assign carrier = 1'b1;
      end
   endgenerate

   assign o_busy  = (state != ST_IDLE);
   assign o_done  = (state == ST_DONE);
   assign o_ir_tx = is_mark(state) && carrier;

endmodule

// File: tb/tb_ir_tx.sv
// Directed bench for ir_tx with shortened phase durations: checks frame
// waveform run lengths, frame timing, start filtering, reset abort and carrier gating.
module tb_ir_tx;

   localparam int D  = 2;
   localparam int LM = 16;
   localparam int LS = 8;
   localparam int BM = 2;
   localparam int ZS = 2;
   localparam int OS = 6;
   localparam int SM = 2;
   localparam int NSEG = 67;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_data = '0;
   logic        i_start = 1'b0;
   logic        o_busy, o_done, o_ir_tx;
   logic        o_busy_c, o_done_c, o_ir_tx_c;

   int checks = 0;
   int failures = 0;

   int   seg [0:79];
   int   seg_n, done_cyc, busy_drop, mark_cyc, carr_hi, carr_bad, run;
   logic lvl;

   always #5 clk = ~clk;

   ir_tx #(.CLK_DIV(D), .CARRIER_EN(0), .T_LEAD_MARK(LM), .T_LEAD_SPACE(LS),
           .T_BIT_MARK(BM), .T_ZERO_SPACE(ZS), .T_ONE_SPACE(OS), .T_STOP_MARK(SM)) dut (
      .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_start(i_start),
      .o_busy(o_busy), .o_done(o_done), .o_ir_tx(o_ir_tx));

   ir_tx #(.CLK_DIV(D), .CARRIER_EN(1), .CARRIER_NUM(4), .T_LEAD_MARK(LM), .T_LEAD_SPACE(LS),
           .T_BIT_MARK(BM), .T_ZERO_SPACE(ZS), .T_ONE_SPACE(OS), .T_STOP_MARK(SM)) dut_c (
      .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_start(i_start),
      .o_busy(o_busy_c), .o_done(o_done_c), .o_ir_tx(o_ir_tx_c));

   task automatic pulse_start(input logic [31:0] data);
      @(posedge clk); #1;
      i_data  = data;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   // Record o_ir_tx run lengths from the cycle after acceptance until o_done.
   task automatic capture(input int poke, input bit chain, input logic [31:0] next_data);
      seg_n = 0; done_cyc = 0; busy_drop = 0; mark_cyc = 0;
      carr_hi = 0; carr_bad = 0; run = 0; lvl = 1'b1;
      for (int c = 1; c <= 2000 && done_cyc == 0; c++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (o_done) begin
            done_cyc = c;
            if (seg_n < 80) seg[seg_n] = run;
            seg_n++;
            if (chain) begin
               i_start = 1'b1;
               i_data  = next_data;
            end
         end else begin
            if (!o_busy) busy_drop++;
            if (o_ir_tx === lvl) run++;
            else begin
               if (seg_n < 80) seg[seg_n] = run;
               seg_n++;
               lvl = o_ir_tx;
               run = 1;
            end
            if (o_ir_tx) begin
               mark_cyc++;
               if (o_ir_tx_c) carr_hi++;
            end else if (o_ir_tx_c) carr_bad++;
            if (c == poke) begin
               i_start = 1'b1;
               i_data  = ~i_data;
            end
         end
      end
   endtask

   task automatic test_frame(input string name, input logic [31:0] data, input int poke,
                             input bit pre_started, input bit chain, input logic [31:0] next_data);
      int e, k, frame;
      if (!pre_started) pulse_start(data);
      capture(poke, chain, next_data);
      frame = D * (LM + LS + 32 * (BM + ZS) + SM + $countones(data) * (OS - ZS));
      checks++;
      if (done_cyc !== frame + 1) begin
         failures++;
         $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, frame + 1);
      end
      checks++;
      if (seg_n !== NSEG) begin
         failures++;
         $display("FAIL %s segment_count: got %0d want %0d", name, seg_n, NSEG);
      end
      for (int i = 0; i < NSEG && i < seg_n && i < 80; i++) begin
         if (i == 0) e = LM * D;
         else if (i == 1) e = LS * D;
         else if (i == NSEG - 1) e = SM * D;
         else if (i % 2 == 0) e = BM * D;
         else begin
            k = (i - 3) / 2;
            e = (data[31 - k] ? OS : ZS) * D;
         end
         checks++;
         if (seg[i] !== e) begin
            failures++;
            $display("FAIL %s seg[%0d]: got %0d cycles want %0d", name, i, seg[i], e);
         end
      end
      checks++;
      if (busy_drop !== 0) begin
         failures++;
         $display("FAIL %s busy_low_mid_frame: got %0d cycles want 0", name, busy_drop);
      end
      checks++;
      if (carr_bad !== 0 || carr_hi == 0 || carr_hi >= mark_cyc) begin
         failures++;
         $display("FAIL %s carrier: got hi=%0d bad=%0d want 0<hi<%0d bad=0", name, carr_hi, carr_bad, mark_cyc);
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, o_done, o_busy);
      end
      if (chain) begin
         @(posedge clk); #1;
         i_start = 1'b0;
      end
   endtask

   task automatic test_reset();
      int bad;
      #7;
      checks++;
      if (o_ir_tx !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got ir=%b busy=%b done=%b want 0 0 0", o_ir_tx, o_busy, o_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (o_ir_tx !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      test_frame("b2b_first", 32'h0000_0000, 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      checks++;
      if (o_busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept_after_done: got busy=%b want 1", o_busy);
      end
      test_frame("b2b_second", 32'hFFFF_FFFF, 0, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic test_abort();
      int dones;
      pulse_start(32'h5A5A_1234);
      repeat (20) @(negedge clk);
      checks++;
      if (o_ir_tx !== 1'b1) begin
         failures++;
         $display("FAIL abort_pre_mark: got %b want 1", o_ir_tx);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (o_ir_tx !== 1'b0 || o_busy !== 1'b0 || o_ir_tx_c !== 1'b0) begin
         failures++;
         $display("FAIL abort_immediate: got ir=%b busy=%b ir_c=%b want 0 0 0", o_ir_tx, o_busy, o_ir_tx_c);
      end
      dones = 0;
      repeat (5) begin
         @(negedge clk);
         if (o_done !== 1'b0) dones++;
      end
      checks++;
      if (dones !== 0) begin
         failures++;
         $display("FAIL abort_no_done: got %0d pulses want 0", dones);
      end
      rst_n   = 1'b1;
      i_data  = 32'hA55A_C33C;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      test_frame("after_abort", 32'hA55A_C33C, 0, 1'b1, 1'b0, 32'h0);
   endtask

   initial begin
      test_reset();
      test_frame("nec_00ff00ff", 32'h00FF_00FF, 0, 1'b0, 1'b0, 32'h0);
      test_frame("all_zeros", 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0);
      test_frame("all_ones", 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0);
      test_frame("ignore_start", 32'h1234_5678, 100, 1'b0, 1'b0, 32'h0);
      test_back_to_back();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
